// File: rtl/wm_actuator_if.sv
// Controller/sensor inputs and actuator drive outputs of the washing-machine actuator driver.
interface wm_actuator_if;
   logic [2:0] stage;
   logic       done;
   logic       input_valve_req;
   logic       output_drain_req;
   logic       door_closed;
   logic       water_full;
   logic       valve_on;
   logic       drain_on;
   logic       motor_en;
   logic       motor_dir;
   logic [1:0] motor_speed;
   logic       door_lock;
   logic [1:0] fault;
   logic       buzzer;

   modport master (
      output stage, done, input_valve_req, output_drain_req, door_closed, water_full,
      input  valve_on, drain_on, motor_en, motor_dir, motor_speed, door_lock, fault, buzzer
   );

   modport slave (
      input  stage, done, input_valve_req, output_drain_req, door_closed, water_full,
      output valve_on, drain_on, motor_en, motor_dir, motor_speed, door_lock, fault, buzzer
   );
endinterface

// File: rtl/wm_actuator_driver.sv
// Washing-machine actuator driver: motor FSM, valve/drain/door-lock drive and fault latch.
// Define WM_BUZZER_EN to build the end-of-cycle buzzer; otherwise buzzer is tied low.
module wm_actuator_driver #(
   parameter int unsigned AGITATE_TICKS = 4,
   parameter int unsigned DWELL_TICKS   = 1,
   parameter int unsigned RAMP_TICKS    = 3,
   parameter int unsigned BRAKE_TICKS   = 4,
   parameter int unsigned OVF_TICKS     = 3,
   parameter int unsigned BUZZ_TICKS    = 8
) (
   input  logic          clk,
   input  logic          reset,
   wm_actuator_if.slave  bus
);

   function automatic int unsigned maxu(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // FAULT holds its counter at BRAKE_TICKS, so the counter must reach that value
   localparam int unsigned CNT_MAX = maxu(maxu(AGITATE_TICKS, DWELL_TICKS),
                                          maxu(RAMP_TICKS, maxu(BRAKE_TICKS, 1)));
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned OVF_W   = $clog2(OVF_TICKS + 1);

   localparam logic [2:0] ST_FILL  = 3'b000;
   localparam logic [2:0] ST_WASH  = 3'b001;
   localparam logic [2:0] ST_RINSE = 3'b010;
   localparam logic [2:0] ST_SPIN  = 3'b011;

   typedef enum logic [3:0] {
      S_OFF, S_AG_CW, S_DWELL_A, S_AG_CCW, S_DWELL_B,
      S_SPIN_RAMP, S_SPIN_HIGH, S_BRAKE, S_FAULT
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OVF_W-1:0]   ovf_q, ovf_d;
   logic [1:0]         fault_q, fault_d;
   logic               valve_q, valve_d, drain_q, drain_d;
   logic               en_q, en_d, dir_q, dir_d, lock_q, lock_d;
   logic [1:0]         spd_q, spd_d;

   logic               agit_c, spin_c, halt_c, tmo_c, ovf_cond_c, door_flt_c, ovf_flt_c;

   function automatic logic [CNT_W-1:0] cnt_term(input state_e s);
      case (s)
         S_AG_CW, S_AG_CCW:     return CNT_W'(AGITATE_TICKS - 1);
         S_DWELL_A, S_DWELL_B:  return CNT_W'(DWELL_TICKS - 1);
         S_SPIN_RAMP:           return CNT_W'(RAMP_TICKS - 1);
         S_BRAKE:               return CNT_W'(BRAKE_TICKS - 1);
         S_FAULT:               return CNT_W'(BRAKE_TICKS);
         default:               return '0;
      endcase
   endfunction

   // Next state, counters and registered output values
   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      agit_c     = (bus.stage == ST_WASH) || (bus.stage == ST_RINSE);
      spin_c     = (bus.stage == ST_SPIN);
      halt_c     = !agit_c && !spin_c;
      tmo_c      = (cnt_q == cnt_term(state_q));
      ovf_cond_c = bus.input_valve_req && bus.water_full;
      door_flt_c = !bus.door_closed && lock_q;
      ovf_flt_c  = ovf_cond_c && (ovf_q == OVF_W'(OVF_TICKS - 1));

      if (!ovf_cond_c)                       ovf_d = '0;
      else if (ovf_q == OVF_W'(OVF_TICKS))   ovf_d = ovf_q;
      else                                   ovf_d = ovf_q + OVF_W'(1);

      case (state_q)
         S_OFF:       if (agit_c) state_d = S_AG_CW; else if (spin_c) state_d = S_SPIN_RAMP;
         S_AG_CW:     if (spin_c) state_d = S_SPIN_RAMP; else if (halt_c) state_d = S_BRAKE;
                      else if (tmo_c) state_d = S_DWELL_A;
         S_DWELL_A:   if (spin_c) state_d = S_SPIN_RAMP; else if (halt_c) state_d = S_BRAKE;
                      else if (tmo_c) state_d = S_AG_CCW;
         S_AG_CCW:    if (spin_c) state_d = S_SPIN_RAMP; else if (halt_c) state_d = S_BRAKE;
                      else if (tmo_c) state_d = S_DWELL_B;
         S_DWELL_B:   if (spin_c) state_d = S_SPIN_RAMP; else if (halt_c) state_d = S_BRAKE;
                      else if (tmo_c) state_d = S_AG_CW;
         S_SPIN_RAMP: if (!spin_c) state_d = S_BRAKE; else if (tmo_c) state_d = S_SPIN_HIGH;
         S_SPIN_HIGH: if (!spin_c) state_d = S_BRAKE;
         S_BRAKE:     if (tmo_c) state_d = S_OFF;
         S_FAULT:     state_d = S_FAULT;
         default:     state_d = S_OFF;
      endcase

      // Door fault wins when both faults appear together
      if ((state_q != S_FAULT) && (door_flt_c || ovf_flt_c)) begin
         state_d = S_FAULT;
         fault_d = door_flt_c ? 2'b01 : 2'b10;
      end

      if (state_d != state_q) cnt_d = '0;
      else if (tmo_c)         cnt_d = cnt_q;
      else                    cnt_d = cnt_q + CNT_W'(1);

      en_d  = 1'b0;
      dir_d = 1'b0;
      spd_d = 2'b00;
      case (state_d)
         S_AG_CW:     begin en_d = 1'b1; spd_d = 2'b01; end
         S_AG_CCW:    begin en_d = 1'b1; dir_d = 1'b1; spd_d = 2'b01; end
         S_SPIN_RAMP: begin en_d = 1'b1; spd_d = 2'b10; end
         S_SPIN_HIGH: begin en_d = 1'b1; spd_d = 2'b11; end
         default:     ;
      endcase

      if (state_d == S_FAULT) begin
         lock_d  = (cnt_d < CNT_W'(BRAKE_TICKS));
         valve_d = 1'b0;
         drain_d = 1'b1;
      end else begin
         lock_d  = (state_d != S_OFF) || agit_c || spin_c || (bus.stage == ST_FILL);
         valve_d = bus.input_valve_req && bus.door_closed && !bus.water_full;
         drain_d = bus.output_drain_req;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         ovf_q   <= '0;
         fault_q <= 2'b00;
         valve_q <= 1'b0;
         drain_q <= 1'b0;
         en_q    <= 1'b0;
         dir_q   <= 1'b0;
         spd_q   <= 2'b00;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         fault_q <= fault_d;
         valve_q <= valve_d;
         drain_q <= drain_d;
         en_q    <= en_d;
         dir_q   <= dir_d;
         spd_q   <= spd_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.valve_on    = valve_q;
   assign bus.drain_on    = drain_q;
   assign bus.motor_en    = en_q;
   assign bus.motor_dir   = dir_q;
   assign bus.motor_speed = spd_q;
   assign bus.door_lock   = lock_q;
   assign bus.fault       = fault_q;

`ifdef WM_BUZZER_EN
   localparam int unsigned BUZZ_W = $clog2(BUZZ_TICKS + 1);

   logic              done_q;
   logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
   logic              buzz_q, buzz_d;

   // Rising edge of done (re)loads the pulse length
   always_comb begin
      buzz_cnt_d = buzz_cnt_q;
      if (bus.done && !done_q)     buzz_cnt_d = BUZZ_W'(BUZZ_TICKS);
      else if (buzz_cnt_q != '0)   buzz_cnt_d = buzz_cnt_q - BUZZ_W'(1);
      buzz_d = (buzz_cnt_d != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q     <= 1'b0;
         buzz_cnt_q <= '0;
         buzz_q     <= 1'b0;
      end else begin
         done_q     <= bus.done;
         buzz_cnt_q <= buzz_cnt_d;
         buzz_q     <= buzz_d;
      end
   end

   assign bus.buzzer = buzz_q;
`else
   assign bus.buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wm_actuator_driver.sv
// Directed scoreboard bench for wm_actuator_driver with default parameters.
module tb_wm_actuator_driver;

`ifdef WM_BUZZER_EN
   localparam bit BZ = 1'b1;
`else
   localparam bit BZ = 1'b0;
`endif

   localparam logic [2:0] IDLE = 3'b111, FILL = 3'b000, WASH = 3'b001,
                          RINSE = 3'b010, SPIN = 3'b011, STOP = 3'b100;

   typedef struct packed {
      logic       valve, drain, en, dir;
      logic [1:0] spd;
      logic       lock;
      logic [1:0] fault;
      logic       buzz;
   } obs_t;

   typedef struct {
      string name;
      obs_t  exp;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   wm_actuator_if bus_if ();

   sb_t sb_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   wm_actuator_driver dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [1:0] spd, input logic dir, input logic lock,
                               input logic valve, input logic drain,
                               input logic [1:0] fault, input logic buzz);
      return {valve, drain, (spd != 2'b00), dir, spd, lock, fault, buzz};
   endfunction

   task automatic set_in(input logic [2:0] st, input logic ivr, input logic odr,
                         input logic dc, input logic wf, input logic dn);
      bus_if.stage            = st;
      bus_if.input_valve_req  = ivr;
      bus_if.output_drain_req = odr;
      bus_if.door_closed      = dc;
      bus_if.water_full       = wf;
      bus_if.done             = dn;
   endtask

   // Queue the outputs expected after the next rising edge, then advance one cycle
   task automatic tick(input string name, input obs_t e);
      sb_t s;
      s.name = name;
      s.exp  = e;
      sb_q.push_back(s);
      @(negedge clk);
   endtask

   // Monitor: outputs are valid every cycle, compared just after each rising edge
   initial begin
      obs_t got;
      sb_t  s;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            s   = sb_q.pop_front();
            got = {bus_if.valve_on, bus_if.drain_on, bus_if.motor_en, bus_if.motor_dir,
                   bus_if.motor_speed, bus_if.door_lock, bus_if.fault, bus_if.buzzer};
            n_vec++;
            if (got !== s.exp) begin
               n_err++;
               $display("FAIL %s @%0t: got {valve,drain,en,dir,spd,lock,fault,buzz}=%b want %b",
                        s.name, $time, got, s.exp);
            end
         end
      end
   end

   initial begin
      obs_t z, offl, cw, ccw, rmp, hi, vlv, f;
      z    = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      offl = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      cw   = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      ccw  = mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      rmp  = mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      hi   = mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      vlv  = mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);

      reset = 1'b1;
      set_in(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      tick("reset", z);
      tick("reset", z);
      reset = 1'b0;
      tick("idle", z);

      // Agitation pattern: CW x4, dwell, CCW x4, dwell, CW
      bus_if.stage = WASH;
      for (int i = 0; i < 12; i++)
         tick("wash", (i < 4) ? cw : (i == 4) ? offl : (i < 9) ? ccw : (i == 9) ? offl : cw);
      bus_if.stage = RINSE;
      tick("rinse_cont", cw);
      tick("rinse_cont", cw);
      tick("rinse_dwell", offl);

      bus_if.stage = SPIN;
      for (int i = 0; i < 3; i++) tick("spin_ramp", rmp);
      tick("spin_high", hi);
      tick("spin_high", hi);
      bus_if.stage = STOP;
      for (int i = 0; i < 4; i++) tick("brake", offl);
      tick("off_unlock", z);
      tick("off_unlock", z);

      // Valve gating and broken overfill runs
      set_in(FILL, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("valve_on", vlv);
      bus_if.output_drain_req = 1'b1;
      tick("drain_req", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0));
      bus_if.output_drain_req = 1'b0;
      for (int r = 0; r < 2; r++) begin
         bus_if.water_full = 1'b1;
         tick("ovf_run", offl);
         tick("ovf_run", offl);
         bus_if.water_full = 1'b0;
         tick("ovf_gap", vlv);
      end

      // Overfill fault after the third consecutive cycle, then sticky
      bus_if.water_full = 1'b1;
      tick("ovf_1", offl);
      tick("ovf_2", offl);
      f = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      tick("ovf_fault", f);
      set_in(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick("ovf_fault_lock", f);
      f.lock = 1'b0;
      tick("ovf_fault_unlock", f);
      tick("ovf_fault_sticky", f);

      reset = 1'b1;
      tick("reset2", z);
      reset = 1'b0;

      // Door opened while locked during wash
      bus_if.stage = WASH;
      tick("door_wash", cw);
      tick("door_wash", cw);
      bus_if.door_closed = 1'b0;
      f = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) tick("door_fault_lock", f);
      f.lock = 1'b0;
      tick("door_fault_unlock", f);
      set_in(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("door_fault_sticky", f);
      tick("door_fault_sticky", f);

      reset = 1'b1;
      tick("reset3", z);
      reset = 1'b0;

      // Both faults in one cycle report the door fault
      set_in(FILL, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick("both_pre", offl);
      tick("both_pre", offl);
      bus_if.door_closed = 1'b0;
      tick("both_fault", mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0));
      reset = 1'b1;
      set_in(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("reset4", z);
      reset = 1'b0;

      // Buzzer pulse and restart
      f = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, BZ);
      bus_if.done = 1'b1;
      tick("buzz", f);
      bus_if.done = 1'b0;
      for (int i = 0; i < 7; i++) tick("buzz", f);
      tick("buzz_end", z);
      tick("buzz_end", z);
      bus_if.done = 1'b1;
      tick("buzz2", f);
      bus_if.done = 1'b0;
      tick("buzz2", f);
      tick("buzz2", f);
      bus_if.done = 1'b1;
      tick("buzz_restart", f);
      bus_if.done = 1'b0;
      for (int i = 0; i < 7; i++) tick("buzz_restart", f);
      tick("buzz_restart_end", z);

      // Asynchronous reset while spinning
      set_in(SPIN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      f = rmp;
      f.drain = 1'b1;
      for (int i = 0; i < 3; i++) tick("spin_drain", f);
      f = hi;
      f.drain = 1'b1;
      tick("spin_drain", f);
      reset = 1'b1;
      tick("reset_spin", z);
      tick("reset_spin", z);
      reset = 1'b0;
      set_in(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("post_reset", z);

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_queue: %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wm_actuator_driver.md
WM_ACTUATOR_DRIVER -- requirements
Module: wm_actuator_driver

Interface
REQ-001 Parameter AGITATE_TICKS, default 4, agitation run time per direction, in cycles.
REQ-002 Parameter DWELL_TICKS, default 1, motor-off gap between agitation directions, in cycles.
REQ-003 Parameter RAMP_TICKS, default 3, spin ramp duration at medium speed, in cycles.
REQ-004 Parameter BRAKE_TICKS, default 4, motor-off settle time before door unlock, in cycles.
REQ-005 Parameter OVF_TICKS, default 3, consecutive overfill cycles before fault.
REQ-006 Parameter BUZZ_TICKS, default 8, buzzer pulse length, in cycles.
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 stage  input  3  controller stage: IDLE=111, FILL=000, WASH=001, RINSE=010, SPIN=011, STOP=100; other values are treated as IDLE.
REQ-010 done  input  1  controller cycle-complete flag.
REQ-011 input_valve_req  input  1  controller request to open the inlet valve.
REQ-012 output_drain_req  input  1  controller request to open the drain.
REQ-013 door_closed  input  1  door sensor, 1 = closed.
REQ-014 water_full  input  1  level sensor, 1 = drum full.
REQ-015 valve_on  output  1  inlet valve drive.
REQ-016 drain_on  output  1  drain pump drive.
REQ-017 motor_en  output  1  motor drive enable.
REQ-018 motor_dir  output  1  0 = CW, 1 = CCW.
REQ-019 motor_speed  output  2  00 off, 01 agitate, 10 ramp, 11 high spin.
REQ-020 door_lock  output  1  door latch drive.
REQ-021 fault  output  2  00 none, 01 door opened while locked, 10 overfill.
REQ-022 buzzer  output  1  end-of-cycle buzzer.

Function
REQ-023 All outputs SHALL be registered, responding one cycle after the inputs that cause them.
REQ-024 Motor FSM states SHALL be: OFF, AG_CW, DWELL_A, AG_CCW, DWELL_B, SPIN_RAMP, SPIN_HIGH, BRAKE, FAULT.
REQ-025 OFF SHALL go to AG_CW when stage is WASH or RINSE, and to SPIN_RAMP when stage is SPIN.
REQ-026 Agitation SHALL cycle AG_CW(AGITATE_TICKS) -> DWELL_A(DWELL_TICKS) -> AG_CCW(AGITATE_TICKS) -> DWELL_B(DWELL_TICKS) -> AG_CW while stage is WASH or RINSE.
REQ-027 A WASH->RINSE change SHALL NOT restart agitation.
REQ-028 Any agitation state SHALL go to SPIN_RAMP when stage becomes SPIN.
REQ-029 SPIN_RAMP SHALL last RAMP_TICKS and then go to SPIN_HIGH; SPIN_HIGH SHALL hold while stage is SPIN.
REQ-030 Any running state SHALL go to BRAKE when stage is IDLE, FILL or STOP; BRAKE SHALL last BRAKE_TICKS and then go to OFF.
REQ-031 Motor outputs per state: AG_CW en=1 dir=0 speed=01; AG_CCW en=1 dir=1 speed=01; SPIN_RAMP en=1 dir=0 speed=10; SPIN_HIGH en=1 dir=0 speed=11; all other states en=0, dir=0, speed=00.
REQ-032 door_lock SHALL be 1 when the state is not OFF, or when stage is FILL, WASH, RINSE or SPIN; otherwise 0.
REQ-033 valve_on SHALL equal input_valve_req & door_closed & ~water_full, forced to 0 in FAULT.
REQ-034 drain_on SHALL equal output_drain_req outside FAULT and SHALL be 1 in FAULT.
REQ-035 A door fault SHALL be raised when door_closed=0 while door_lock=1: next state FAULT, fault=01.
REQ-036 An overfill fault SHALL be raised when input_valve_req & water_full holds for OVF_TICKS consecutive cycles: next state FAULT, fault=10; any break in the condition clears the run counter.
REQ-037 If both faults arise in the same cycle, fault SHALL be 01.
REQ-038 FAULT SHALL be sticky until reset; in FAULT, motor_en=0 and door_lock=1 for BRAKE_TICKS, then door_lock=0.
REQ-039 Tick counters SHALL saturate at their terminal value and clear on every state change.

Reset
REQ-040 Reset SHALL force state OFF and clear all counters; all outputs SHALL be 0 and fault=00, including when reset is asserted mid-spin.

Configuration
REQ-041 Macro WM_BUZZER_EN defined: a rising edge of done SHALL drive buzzer=1 for exactly BUZZ_TICKS cycles, and a new edge during the pulse SHALL restart the count.
REQ-042 Macro WM_BUZZER_EN undefined: buzzer SHALL be constant 0 and no buzzer logic SHALL be synthesized.

Verification
REQ-043 Hold stage=WASH for 12 cycles -> CW for 4 cycles, off for 1, CCW for 4, off for 1, CW again; door_lock=1 throughout.
REQ-044 Step stage SPIN then STOP -> speed=10 for 3 cycles, then 11; on STOP, 4 BRAKE cycles with door_lock=1, then OFF with door_lock=0.
REQ-045 Drop door_closed during WASH -> fault=01, motor_en=0, drain_on=1; door_lock releases after 4 cycles; state stays FAULT until reset.
REQ-046 Hold input_valve_req=1 and water_full=1 for 3 cycles -> valve_on=0 throughout, fault=10 after the 3rd cycle; a 2-cycle run followed by a 1-cycle gap raises no fault.
REQ-047 Pulse done with WM_BUZZER_EN defined -> buzzer=1 for 8 cycles; without the macro -> buzzer stays 0; reset during spin -> all outputs 0 on the next edge.
